// File: rtl/morse_symbolizer_pkg.sv
// Shared symbol codes and FSM state encoding for the Morse symbolizer and its downstream decoder.
package morse_symbolizer_pkg;

    localparam logic [1:0] SYM_DOT      = 2'b00;
    localparam logic [1:0] SYM_DASH     = 2'b01;
    localparam logic [1:0] SYM_CHAR_END = 2'b10;
    localparam logic [1:0] SYM_WORD_END = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10
    } state_t;

endpackage

// File: rtl/morse_debounce.sv
// Key-line conditioner: 2-flop synchronizer followed by a run-length filter that only
// accepts a new level after DEB_CYCLES identical synchronized samples.
module morse_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level
);

    localparam int RUN_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [RUN_W-1:0] run;

    // run counts how long the synchronized input has disagreed with the accepted level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            run   <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            if (sync2 == level) begin
                run <= '0;
            end else if (run == RUN_W'(DEB_CYCLES - 1)) begin
                level <= sync2;
                run   <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_symbolizer.sv
// Morse key-line symbolizer: times marks/spaces and emits DOT/DASH/CHAR_END/WORD_END through a
// 1-deep valid/ready register. Define MORSE_DEBOUNCE_EN to insert the synchronizer/filter stage.
module morse_symbolizer
    import morse_symbolizer_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [1:0] sym,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       busy,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] CHAR_GAP  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP  = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if ((2 ** CNT_W) - 1 < 5 * UNIT_CYCLES || DEB_CYCLES < 1) begin : g_bad_cfg
        $error("morse_symbolizer: CNT_W too narrow for 5*UNIT_CYCLES or DEB_CYCLES < 1");
    end

    logic             key;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             emit;
    logic [1:0]       emit_code;

`ifdef MORSE_DEBOUNCE_EN
    morse_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .level(key)
    );
`else
    assign key = in;
`endif

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign busy    = (state != ST_IDLE);

    // Thresholds are tested on the count value the current sample produces,
    // so each gap boundary fires exactly once, on the cycle it is crossed.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        emit       = 1'b0;
        emit_code  = SYM_DOT;
        case (state)
            ST_IDLE: begin
                next_cnt = '0;
                if (key) begin
                    next_state = ST_MARK;
                    next_cnt   = CNT_ONE;
                end
            end
            ST_MARK: begin
                if (key) begin
                    next_cnt = cnt_inc;
                end else begin
                    emit       = 1'b1;
                    emit_code  = (cnt < CHAR_GAP) ? SYM_DOT : SYM_DASH;
                    next_state = ST_SPACE;
                    next_cnt   = CNT_ONE;
                end
            end
            ST_SPACE: begin
                if (key) begin
                    next_state = ST_MARK;
                    next_cnt   = CNT_ONE;
                end else begin
                    next_cnt = cnt_inc;
                    if (cnt_inc == CHAR_GAP) begin
                        emit      = 1'b1;
                        emit_code = SYM_CHAR_END;
                    end else if (cnt_inc == WORD_GAP) begin
                        emit       = 1'b1;
                        emit_code  = SYM_WORD_END;
                        next_state = ST_IDLE;
                        next_cnt   = '0;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // A new symbol may replace one being consumed in the same cycle; otherwise a full register wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym       <= SYM_DOT;
            sym_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!sym_valid || sym_ready) begin
                sym       <= emit_code;
                sym_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (sym_ready) begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_morse_symbolizer.sv
// Testbench for morse_symbolizer (default build, UNIT_CYCLES=4): directed scenarios plus
// random mark/gap trains checked against a duration-based symbol model.
module tb_morse_symbolizer;

    localparam int         UNIT     = 4;
    localparam logic [1:0] DOT      = 2'b00;
    localparam logic [1:0] DASH     = 2'b01;
    localparam logic [1:0] CHAR_END = 2'b10;
    localparam logic [1:0] WORD_END = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key = 1'b0;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_ready = 1'b1;
    logic       busy;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    int         marks[$];
    int         gaps[$];
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic       monitor_en = 1'b0;

    morse_symbolizer #(
        .UNIT_CYCLES(UNIT),
        .CNT_W      (8),
        .DEB_CYCLES (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (key),
        .sym      (sym),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Transfers are recorded mid-cycle; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (monitor_en && sym_valid && sym_ready) got_q.push_back(sym);
    end

    task automatic hold(input logic lvl, input int n);
        key = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key       = 1'b0;
        sym_ready = 1'b1;
        #15;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Expected symbols follow purely from the durations: mark length picks DOT/DASH,
    // gap length reaching 2 or 5 units adds CHAR_END / WORD_END.
    task automatic play_and_check(input string name);
        exp_q = {};
        got_q = {};
        foreach (marks[i]) begin
            exp_q.push_back((marks[i] < 2 * UNIT) ? DOT : DASH);
            if (gaps[i] >= 2 * UNIT) exp_q.push_back(CHAR_END);
            if (gaps[i] >= 5 * UNIT) exp_q.push_back(WORD_END);
        end
        monitor_en = 1'b1;
        foreach (marks[i]) begin
            hold(1'b1, marks[i]);
            hold(1'b0, gaps[i]);
        end
        hold(1'b0, 3);
        monitor_en = 1'b0;
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL %s count: got %0d symbols, expected %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL %s sym[%0d]: got %b, expected %b", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b1;
        #3;
        vectors++;
        if ({sym, sym_valid, busy, overrun} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b, expected 00000", {sym, sym_valid, busy, overrun});
        end
        do_reset();
        hold(1'b0, 2);
        vectors++;
        if ({sym_valid, busy, overrun} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %b, expected 000", {sym_valid, busy, overrun});
        end
    endtask

    task automatic test_dot_word();
        logic       exp_valid;
        logic [1:0] exp_sym;
        do_reset();
        hold(1'b1, 4);
        for (int n = 1; n <= 22; n++) begin
            hold(1'b0, 1);
            exp_valid = (n == 1) || (n == 8) || (n == 20);
            exp_sym   = (n == 1) ? DOT : (n == 8) ? CHAR_END : WORD_END;
            vectors++;
            if (sym_valid !== exp_valid) begin
                miscompares++;
                $display("[TB] FAIL dot_word valid@low%0d: got %b, expected %b", n, sym_valid, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (sym !== exp_sym) begin
                    miscompares++;
                    $display("[TB] FAIL dot_word sym@low%0d: got %b, expected %b", n, sym, exp_sym);
                end
            end
            vectors++;
            if (busy !== (n < 20)) begin
                miscompares++;
                $display("[TB] FAIL dot_word busy@low%0d: got %b, expected %b", n, busy, (n < 20));
            end
        end
    endtask

    task automatic test_threshold();
        do_reset();
        marks = '{7, 8, 12};
        gaps  = '{20, 20, 20};
        play_and_check("threshold");
    endtask

    task automatic test_gap();
        do_reset();
        marks = '{4, 4};
        gaps  = '{7, 20};
        play_and_check("gap7");
        do_reset();
        marks = '{4, 4};
        gaps  = '{8, 20};
        play_and_check("gap8");
    endtask

    task automatic test_backpressure();
        do_reset();
        sym_ready = 1'b0;
        hold(1'b1, 4);
        hold(1'b0, 1);
        vectors++;
        if ({sym_valid, sym, overrun} !== {1'b1, DOT, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL bp_first: got %b, expected %b", {sym_valid, sym, overrun}, {1'b1, DOT, 1'b0});
        end
        hold(1'b0, 2);
        hold(1'b1, 8);
        hold(1'b0, 1);
        vectors++;
        if ({sym_valid, sym, overrun} !== {1'b1, DOT, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL bp_held: got %b, expected %b", {sym_valid, sym, overrun}, {1'b1, DOT, 1'b1});
        end
        sym_ready = 1'b1;
        hold(1'b0, 1);
        sym_ready = 1'b0;
        vectors++;
        if ({sym_valid, overrun} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL bp_accept_once: got %b, expected 01", {sym_valid, overrun});
        end
        hold(1'b0, 6);
        vectors++;
        if ({sym_valid, sym} !== {1'b1, CHAR_END}) begin
            miscompares++;
            $display("[TB] FAIL bp_char_end: got %b, expected %b", {sym_valid, sym}, {1'b1, CHAR_END});
        end
        sym_ready = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        marks = '{300, 259};
        gaps  = '{20, 20};
        play_and_check("saturation");
    endtask

    task automatic test_reset_mid_mark();
        do_reset();
        hold(1'b1, 5);
        reset = 1'b1;
        key   = 1'b0;
        #2;
        vectors++;
        if ({sym_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mid_mark_reset: got %b, expected 00", {sym_valid, busy});
        end
        #2;
        reset = 1'b0;
        got_q = {};
        monitor_en = 1'b1;
        hold(1'b0, 25);
        monitor_en = 1'b0;
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL mid_mark_no_symbol: got %0d symbols, expected 0", got_q.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            marks = {};
            gaps  = {};
            for (int i = 0; i < 12; i++) begin
                marks.push_back(int'($urandom_range(1, 14)));
                gaps.push_back((i == 11) ? int'($urandom_range(20, 24)) : int'($urandom_range(1, 24)));
            end
            play_and_check("random");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_dot_word();
        test_threshold();
        test_gap();
        test_backpressure();
        test_saturation();
        test_reset_mid_mark();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
